// File: rtl/fault_pkg.sv
// Shared types and constants for the fault-detection scheduler slice.
package fault_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned SEV_W  = 3;

  localparam logic [SEV_W-1:0] SEV_NONE = 3'd0;
  localparam logic [SEV_W-1:0] SEV_LOW  = 3'd1;
  localparam logic [SEV_W-1:0] SEV_MED  = 3'd2;
  localparam logic [SEV_W-1:0] SEV_HIGH = 3'd3;
  localparam logic [SEV_W-1:0] SEV_CRIT = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } state_t;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] oh;
    oh     = '0;
    oh[ch] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fault_alarm_latch.sv
// Sticky alarm register: edge-detects datapath fault reports, keeps the
// highest-severity event until acknowledged.
module fault_alarm_latch
  import fault_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SEV_W-1:0] fault_sev,
  input  logic [CH_W-1:0]  fault_ch,
  input  logic             alarm_ack,
  output logic             alarm,
  output logic [SEV_W-1:0] alarm_sev,
  output logic [CH_W-1:0]  alarm_ch
);

  logic [SEV_W-1:0] prev_sev;
  logic [CH_W-1:0]  prev_ch;
  logic             new_evt;
  logic             load;

  // A report is new when it is non-zero and differs from last cycle's report.
  assign new_evt = (fault_sev != SEV_NONE) &&
                   ({fault_sev, fault_ch} != {prev_sev, prev_ch});

  // Load on an idle alarm, a strictly higher severity, or an ack racing the event.
  assign load = new_evt && (!alarm || (fault_sev > alarm_sev) || alarm_ack);

  // Alarm register with event-over-ack priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_sev  <= SEV_NONE;
      prev_ch   <= '0;
      alarm     <= 1'b0;
      alarm_sev <= SEV_NONE;
      alarm_ch  <= '0;
    end else begin
      prev_sev <= fault_sev;
      prev_ch  <= fault_ch;
      if (load) begin
        alarm     <= 1'b1;
        alarm_sev <= fault_sev;
        alarm_ch  <= fault_ch;
      end else if (alarm_ack) begin
        alarm     <= 1'b0;
        alarm_sev <= SEV_NONE;
        alarm_ch  <= '0;
      end
    end
  end

endmodule

// File: rtl/fault_scan_sched.sv
// Round-robin burst scheduler feeding the fault datapath, plus alarm front-end.
module fault_scan_sched
  import fault_pkg::NUM_CH;
  import fault_pkg::CH_W;
  import fault_pkg::SEV_W;
  import fault_pkg::state_t;
  import fault_pkg::ch_onehot;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BURST   = 4,
  parameter int unsigned GAP     = 0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [DATA_W-1:0]        r0,
  output logic [CH_W-1:0]          check,
  output logic                     smp_vld,
  input  logic [SEV_W-1:0]         fault_sev,
  input  logic [CH_W-1:0]          fault_ch,
  output logic                     alarm,
  output logic [SEV_W-1:0]         alarm_sev,
  output logic [CH_W-1:0]          alarm_ch,
  input  logic                     alarm_ack,
  output logic [7:0]               skip_cnt
);

  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST + 1) : 1;
  localparam int unsigned TW = 8;
  localparam int unsigned GW = 4;

  // After a visit ends, go through the gap only when one is configured.
  localparam state_t LEAVE_ST = (GAP > 0) ? fault_pkg::GAP : fault_pkg::SELECT;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   cur;
  logic [BW-1:0]     burst_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [DATA_W-1:0] cur_data;
  logic              xfer;
  logic              burst_done;
  logic              tmo_hit;
  logic              gap_last;

  // Only the channel being visited is offered ready, and only while waiting.
  always_comb begin
    ch_ready = '0;
    if (state == fault_pkg::WAIT) begin
      ch_ready = ch_onehot(cur);
    end
  end

  assign cur_data   = ch_data[32'(cur) * DATA_W +: DATA_W];
  assign xfer       = ch_valid[cur] && ch_ready[cur];
  assign burst_done = xfer && (burst_cnt == BW'(BURST - 1));
  assign tmo_hit    = (state == fault_pkg::WAIT) && !xfer &&
                      (tmo_cnt == TW'(TIMEOUT - 1));
  assign gap_last   = (gap_cnt == GW'(GAP - 1));

  // Scheduler FSM with registered sample issue and skip counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= fault_pkg::IDLE;
      ptr       <= '0;
      cur       <= '0;
      burst_cnt <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      r0        <= '0;
      check     <= '0;
      smp_vld   <= 1'b0;
      skip_cnt  <= '0;
    end else begin
      smp_vld <= xfer;
      if (xfer) begin
        r0    <= cur_data;
        check <= cur;
      end

      case (state)
        fault_pkg::IDLE: begin
          if (enable) begin
            state <= fault_pkg::SELECT;
          end
        end

        fault_pkg::SELECT: begin
          cur       <= ptr;
          burst_cnt <= '0;
          tmo_cnt   <= '0;
          state     <= enable ? fault_pkg::WAIT : fault_pkg::IDLE;
        end

        fault_pkg::WAIT: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + BW'(1);
            tmo_cnt   <= '0;
            if (burst_done) begin
              ptr     <= ptr + CH_W'(1);
              gap_cnt <= '0;
              state   <= LEAVE_ST;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_hit) begin
              ptr     <= ptr + CH_W'(1);
              gap_cnt <= '0;
              state   <= LEAVE_ST;
              if (skip_cnt != 8'hFF) begin
                skip_cnt <= skip_cnt + 8'd1;
              end
            end
          end
        end

        fault_pkg::GAP: begin
          if (!enable) begin
            gap_cnt <= '0;
            state   <= fault_pkg::IDLE;
          end else if (gap_last) begin
            gap_cnt <= '0;
            state   <= fault_pkg::SELECT;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: state <= fault_pkg::IDLE;
      endcase
    end
  end

  fault_alarm_latch u_alarm (
    .clk       (clk),
    .reset     (reset),
    .fault_sev (fault_sev),
    .fault_ch  (fault_ch),
    .alarm_ack (alarm_ack),
    .alarm     (alarm),
    .alarm_sev (alarm_sev),
    .alarm_ch  (alarm_ch)
  );

endmodule

// File: tb/tb_fault_scan_sched.sv
// Scoreboard bench for fault_scan_sched: procedural visit model + alarm model.
module tb_fault_scan_sched;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BURST  = 4;
  localparam int unsigned GAP_C  = 0;
  localparam int unsigned TMO    = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  ch_valid;
  logic [31:0] ch_data;
  logic [3:0]  ch_ready;
  logic [7:0]  r0;
  logic [1:0]  check;
  logic        smp_vld;
  logic [2:0]  fault_sev;
  logic [1:0]  fault_ch;
  logic        alarm;
  logic [2:0]  alarm_sev;
  logic [1:0]  alarm_ch;
  logic        alarm_ack;
  logic [7:0]  skip_cnt;

  always #5 clk = ~clk;

  fault_scan_sched #(
    .DATA_W (DATA_W),
    .BURST  (BURST),
    .GAP    (GAP_C),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_ready  (ch_ready),
    .r0        (r0),
    .check     (check),
    .smp_vld   (smp_vld),
    .fault_sev (fault_sev),
    .fault_ch  (fault_ch),
    .alarm     (alarm),
    .alarm_sev (alarm_sev),
    .alarm_ch  (alarm_ch),
    .alarm_ack (alarm_ack),
    .skip_cnt  (skip_cnt)
  );

  typedef struct packed { logic [7:0] d; logic [1:0] c; } smp_t;
  typedef struct packed { logic a; logic [2:0] s; logic [1:0] c; } alm_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   model_on = 1'b0;
  bit   mon_on   = 1'b0;
  bit   alarm_done = 1'b0;
  bit   pushed_now = 1'b0;
  int   m_skip = 0;
  logic [3:0] exp_ready = '0;
  smp_t sq[$];
  alm_t aq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_edge();
    @(posedge clk);
    pushed_now = 1'b0;
  endtask

  // Visit-level scheduler model: idle, select, wait for a burst or timeout, gap.
  initial begin : sched_model
    int ptr;
    int cnt;
    int tmo;
    bit to_idle;
    ptr = 0;
    wait (model_on);
    forever begin
      exp_ready = '0;
      do m_edge(); while (!enable);
      to_idle = 1'b0;
      while (!to_idle) begin
        exp_ready = '0;
        m_edge();
        if (!enable) begin
          to_idle = 1'b1;
        end else begin
          cnt = 0;
          tmo = 0;
          exp_ready = 4'(1 << ptr);
          forever begin
            m_edge();
            if (ch_valid[ptr]) begin
              sq.push_back(smp_t'{ch_data[ptr*8 +: 8], 2'(ptr)});
              pushed_now = 1'b1;
              cnt++;
              tmo = 0;
              if (cnt == int'(BURST)) break;
            end else begin
              tmo++;
              if (tmo == int'(TMO)) begin
                if (m_skip < 255) m_skip++;
                break;
              end
            end
          end
          ptr = (ptr + 1) % 4;
          exp_ready = '0;
          for (int g = 0; g < int'(GAP_C) && !to_idle; g++) begin
            m_edge();
            if (!enable) to_idle = 1'b1;
          end
        end
      end
    end
  end

  // Alarm model: highest new report wins, ack clears, an event beats an ack.
  initial begin : alarm_model
    logic [2:0] ps;
    logic [2:0] as_;
    logic [1:0] pc;
    logic [1:0] ac;
    logic       a;
    bit         evt;
    ps = '0; pc = '0; as_ = '0; ac = '0; a = 1'b0;
    wait (model_on);
    forever begin
      @(posedge clk);
      evt = (fault_sev != 3'd0) && ((fault_sev != ps) || (fault_ch != pc));
      if (evt && (!a || fault_sev > as_ || alarm_ack)) begin
        a = 1'b1; as_ = fault_sev; ac = fault_ch;
      end else if (alarm_ack) begin
        a = 1'b0; as_ = '0; ac = '0;
      end
      ps = fault_sev;
      pc = fault_ch;
      aq.push_back(alm_t'{a, as_, ac});
    end
  end

  // Monitor: compares DUT outputs with the queued expectations every cycle.
  initial begin : monitor
    smp_t       e;
    alm_t       ae;
    logic [7:0] last_r0;
    logic [1:0] last_ck;
    last_r0 = '0;
    last_ck = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("ch_ready", 32'(ch_ready), 32'(exp_ready));
        chk("smp_vld_timing", 32'(smp_vld), 32'(pushed_now));
        if (smp_vld) begin
          if (sq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL smp_unexpected: got r0=%0d check=%0d expected no sample", r0, check);
          end else begin
            e = sq.pop_front();
            chk("r0", 32'(r0), 32'(e.d));
            chk("check", 32'(check), 32'(e.c));
            last_r0 = e.d;
            last_ck = e.c;
          end
        end else begin
          chk("r0_hold", 32'(r0), 32'(last_r0));
          chk("check_hold", 32'(check), 32'(last_ck));
        end
        if (aq.size() > 0) begin
          ae = aq.pop_front();
          chk("alarm", 32'(alarm), 32'(ae.a));
          chk("alarm_sev", 32'(alarm_sev), 32'(ae.s));
          chk("alarm_ch", 32'(alarm_ch), 32'(ae.c));
        end
      end
    end
  end

  // Alarm stimulus: directed sequence, random reports, then ack racing an event.
  initial begin : alarm_stim
    wait (model_on);
    @(negedge clk);
    fault_sev = 3'd2; fault_ch = 2'd1;
    repeat (10) @(negedge clk);
    chk("a_hold_alarm", 32'(alarm), 32'd1);
    chk("a_hold_sev", 32'(alarm_sev), 32'd2);
    chk("a_hold_ch", 32'(alarm_ch), 32'd1);
    fault_sev = 3'd4; fault_ch = 2'd3;
    @(negedge clk);
    chk("a_over_sev", 32'(alarm_sev), 32'd4);
    chk("a_over_ch", 32'(alarm_ch), 32'd3);
    fault_sev = 3'd1; fault_ch = 2'd0;
    repeat (2) @(negedge clk);
    chk("a_low_ignored", 32'(alarm_sev), 32'd4);
    fault_sev = 3'd0;
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    chk("a_ack_alarm", 32'(alarm), 32'd0);
    chk("a_ack_sev", 32'(alarm_sev), 32'd0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 20) begin
        fault_sev = 3'($urandom_range(4));
        fault_ch  = 2'($urandom_range(3));
      end
      alarm_ack = ($urandom_range(99) < 5);
      @(negedge clk);
    end
    alarm_ack = 1'b0;
    fault_sev = 3'd4; fault_ch = 2'd1;
    repeat (2) @(negedge clk);
    fault_sev = 3'd3; fault_ch = 2'd2;
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    chk("a_ackevt_alarm", 32'(alarm), 32'd1);
    chk("a_ackevt_sev", 32'(alarm_sev), 32'd3);
    chk("a_ackevt_ch", 32'(alarm_ch), 32'd2);
    alarm_done = 1'b1;
  end

  // Main stimulus: reset, directed scheduler patterns, random traffic, reset mid-burst.
  initial begin : main_stim
    int prob [4];
    int k;
    reset = 1'b0; enable = 1'b0; ch_valid = '0; ch_data = '0;
    alarm_ack = 1'b0; fault_sev = '0; fault_ch = '0;
    repeat (3) @(negedge clk);
    chk("rst_ch_ready", 32'(ch_ready), 32'd0);
    chk("rst_smp_vld", 32'(smp_vld), 32'd0);
    chk("rst_r0", 32'(r0), 32'd0);
    chk("rst_check", 32'(check), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_skip", 32'(skip_cnt), 32'd0);
    reset = 1'b1;
    model_on = 1'b1;
    mon_on = 1'b1;

    // All channels valid with fixed data.
    @(negedge clk);
    enable = 1'b1;
    ch_valid = 4'hF;
    ch_data = {8'd40, 8'd30, 8'd20, 8'd10};
    repeat (45) @(negedge clk);
    chk("seg1_skip", 32'(skip_cnt), 32'(m_skip));

    // Channel 1 silent: its visits time out.
    ch_valid = 4'b1101;
    repeat (60) @(negedge clk);
    chk("seg2_skip", 32'(skip_cnt), 32'(m_skip));

    // Channel 0 valid toggles every cycle.
    for (int i = 0; i < 60; i++) begin
      ch_valid = {3'b111, ~ch_valid[0]};
      ch_data = $urandom;
      @(negedge clk);
    end
    chk("seg3_skip", 32'(skip_cnt), 32'(m_skip));

    // Enable dropped at random points with full traffic.
    ch_valid = 4'hF;
    for (int i = 0; i < 200; i++) begin
      ch_data = $urandom;
      enable = ($urandom_range(99) >= 12);
      @(negedge clk);
    end
    chk("seg4_skip", 32'(skip_cnt), 32'(m_skip));

    // Fully random traffic with per-channel valid densities.
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        for (int c = 0; c < 4; c++) prob[c] = $urandom_range(100);
      end
      for (int c = 0; c < 4; c++) ch_valid[c] = ($urandom_range(99) < prob[c]);
      ch_data = $urandom;
      enable = ($urandom_range(99) < 95);
      @(negedge clk);
    end

    // Drain and compare totals.
    enable = 1'b0;
    ch_valid = 4'hF;
    repeat (30) @(negedge clk);
    chk("sq_drained", 32'(sq.size()), 32'd0);
    chk("skip_final", 32'(skip_cnt), 32'(m_skip));
    wait (alarm_done);
    @(negedge clk);

    // Reset while a burst is in progress.
    mon_on = 1'b0;
    enable = 1'b1;
    k = 0;
    while (ch_ready == 4'd0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (ch_ready == 4'd0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rst_setup: ch_ready stayed 0 for %0d cycles", k);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ch_ready", 32'(ch_ready), 32'd0);
    chk("mid_rst_smp_vld", 32'(smp_vld), 32'd0);
    chk("mid_rst_r0", 32'(r0), 32'd0);
    chk("mid_rst_check", 32'(check), 32'd0);
    chk("mid_rst_alarm", 32'(alarm), 32'd0);
    chk("mid_rst_alarm_sev", 32'(alarm_sev), 32'd0);
    chk("mid_rst_alarm_ch", 32'(alarm_ch), 32'd0);
    chk("mid_rst_skip", 32'(skip_cnt), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fault_scan_sched.md
Name: fault_scan_sched

Overview:
- Scheduler and alarm front-end for the 4-channel fault-detection datapath.
- Arbitrates four sensor sample streams (valid/ready) in round-robin bursts and drives the datapath's r0/check inputs plus a sample-enable.
- Captures the datapath's severity/channel outputs into a sticky, acknowledged alarm register.
- Sits between the sensor interfaces and the fault datapath, directly below top-level I/O.

Parameters:
- DATA_W, 8, sample width; must equal the datapath r0 width.
- BURST, 4, accepted samples per channel visit; matches the datapath's 4-sample averaging window.
- GAP, 0, idle cycles inserted between bursts (0..15).
- TIMEOUT, 255, cycles to wait in WAIT with no valid before skipping the channel (1..255).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  scheduler run enable.
- ch_valid  in  4  per-channel sample valid.
- ch_data  in  4*DATA_W  packed samples; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_ready  out  4  per-channel ready, one-hot or zero.
- r0  out  DATA_W  sample to datapath.
- check  out  2  channel index to datapath.
- smp_vld  out  1  datapath accumulates only when high.
- fault_sev  in  3  datapath severity (0 none, 1..4).
- fault_ch  in  2  datapath fault channel.
- alarm  out  1  sticky alarm.
- alarm_sev  out  3  latched severity.
- alarm_ch  out  2  latched channel.
- alarm_ack  in  1  clears alarm.
- skip_cnt  out  8  saturating count of timeouts.

Behaviour:
- Reset (reset==0 at posedge): all outputs 0; FSM=IDLE; ptr=0; burst_cnt=0; tmo_cnt=0; gap_cnt=0; prev_sev=0; prev_ch=0.
- FSM states and transitions:
  - IDLE: enable=1 goes to SELECT.
  - SELECT (1 cycle): cur=ptr, burst_cnt=0, tmo_cnt=0; goes to WAIT.
  - WAIT: ch_ready[cur]=1 combinationally in this state only; every other state drives ch_ready=0.
    - Transfer when ch_valid[cur] and ch_ready[cur] are both high: burst_cnt++, tmo_cnt=0.
    - On the transfer where burst_cnt reaches BURST: ptr=ptr+1 mod 4; goes to GAP if GAP>0, else SELECT.
    - Any cycle without a transfer: tmo_cnt++.
    - tmo_cnt reaching TIMEOUT: skip_cnt++ (saturating at 255), ptr advances, goes to GAP/SELECT. A partially issued burst is abandoned; the datapath's per-channel counter continues on the next visit.
  - GAP: gap_cnt counts GAP cycles, then goes to SELECT.
- Issue latency: a transfer at cycle N gives smp_vld=1 with r0=data and check=cur at N+1. smp_vld is a single-cycle pulse per transfer. Maximum rate is one sample per cycle inside a burst.
- r0 and check hold their last values when smp_vld=0.
- enable=0 is sampled in SELECT or GAP only and goes to IDLE. A burst in progress (WAIT) always completes or times out first. ptr is preserved across IDLE.
- Alarm capture:
  - new_evt = (fault_sev!=0) and ({fault_sev,fault_ch} != {prev_sev,prev_ch}).
  - prev_sev/prev_ch register fault_sev/fault_ch every cycle.
  - On new_evt: load when alarm==0 or fault_sev>alarm_sev; sets alarm=1, alarm_sev, alarm_ch. An equal or lower severity event is dropped while alarm==1.
  - alarm_ack with no new_evt: next cycle alarm=0, alarm_sev=0, alarm_ch=0.
  - alarm_ack together with new_evt: the event wins; alarm stays 1 with the new values.
- Reset mid-burst: everything returns to reset values on the next edge. Any in-flight sample is dropped, not issued.

Decomposition:
- Shared package fault_pkg:
  - state enum {IDLE, SELECT, WAIT, GAP}.
  - Severity constants SEV_NONE=0, SEV_LOW=1, SEV_MED=2, SEV_HIGH=3, SEV_CRIT=4.
  - NUM_CH=4.
- One natural sub-module, fault_alarm_latch: edge-detect, priority load and ack logic for the alarm register.

Test Plan:
- All ch_valid=1, ch_data = {8'd40, 8'd30, 8'd20, 8'd10}, GAP=0, enable=1: four smp_vld pulses with r0=10, check=0, then a 1-cycle bubble (SELECT), then four with r0=20, check=1; sequence wraps to channel 0 after channel 3.
- Only ch_valid[1]=0, TIMEOUT=5: channel 1 WAIT lasts exactly 5 cycles with ch_ready[1]=1, skip_cnt=1, no smp_vld with check=1, then channel 2 is served.
- ch_valid[0] toggling 1,0,1,0 on every cycle: smp_vld pulses exactly one cycle after each handshake; burst completes after 4 transfers spread over 7 cycles.
- enable dropped after 2 of 4 transfers on channel 2: the remaining 2 transfers still complete, FSM enters IDLE from SELECT with ptr=3, and re-enable starts at channel 3.
- fault_sev=2, fault_ch=1 held for 10 cycles: alarm=1 after one edge and stays 1 with sev 2; then fault_sev=4, fault_ch=3 overwrites; then fault_sev=1 is ignored; alarm_ack clears to 0.
- alarm_ack asserted in the same cycle as a new fault_sev=3 event: alarm stays 1 with alarm_sev=3. Then reset=0 for 1 cycle mid-burst: all outputs 0 and ch_ready=0.
